// File: rtl/arb_pkg.sv
// Shared types and address-map constants for the round-robin arbiter / slave decoder.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, DECODE, XFER, RESP} state_t;

  localparam logic [31:0] BASE_DEF = 32'hFFEF_0200;
  localparam logic [31:0] MASK_DEF = 32'hFFEF_FF00;
  localparam int          ID_LSB   = 12;

  // Slave id lives in address bits [15:12].
  function automatic logic [3:0] slv_id(input logic [31:0] a);
    return a[ID_LSB +: 4];
  endfunction

endpackage

// File: rtl/arb_rr_decode_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  int w_k;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_k       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = (int'(i_ptr) + i) % N;
      if (i_req[w_k]) begin
        o_gnt_idx = IW'(w_k);
        o_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_decode.sv
// Round-robin arbiter over NMST masters with address decode onto a shared NSLV-slave bus.
module arb_rr_decode
  import arb_pkg::*;
#(
  parameter int             NMST = 4,
  parameter int             NSLV = 16,
  parameter int             AW   = 32,
  parameter int             DW   = 32,
  parameter logic [AW-1:0]  BASE = AW'(BASE_DEF),
  parameter logic [AW-1:0]  MASK = AW'(MASK_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NMST-1:0]     m_req,
  input  logic [NMST*AW-1:0]  m_addr,
  input  logic [NMST-1:0]     m_rw,
  input  logic [NMST*DW-1:0]  m_wdata,
  output logic [NMST-1:0]     m_ack,
  output logic                m_err,
  output logic [DW-1:0]       m_rdata,
  output logic [NSLV-1:0]     sel,
  output logic [AW-1:0]       addr,
  output logic                RW,
  output logic [DW-1:0]       DataToSlave,
  input  logic [DW-1:0]       DataFromSlave
);

  localparam int IW = $clog2(NMST);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_addr;
  logic            r_rw;
  logic [DW-1:0]   r_wdata;
  logic            r_hit;
  logic [3:0]      r_id;

  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [3:0]      w_id;
  logic            w_hit;
  logic [IW-1:0]   w_ptr_nxt;
  logic [NSLV-1:0] w_sel;

  rr_pick #(.N(NMST), .IW(IW)) u_pick (
    .i_req     (m_req),
    .i_ptr     (r_ptr),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_id      = slv_id(32'(r_addr));
  assign w_hit     = (int'(w_id) < NSLV) &&
                     ((r_addr & MASK) == (BASE | (AW'(w_id) << ID_LSB)));
  assign w_ptr_nxt = (r_idx == IW'(NMST - 1)) ? '0 : r_idx + 1'b1;

  // Select is only ever raised for the single XFER cycle of a decoded hit.
  always_comb begin
    w_sel = '0;
    if (r_state == XFER && r_hit) w_sel[r_id] = 1'b1;
  end
  assign sel = w_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_hit       <= 1'b0;
      r_id        <= '0;
      addr        <= '0;
      RW          <= 1'b0;
      DataToSlave <= '0;
      m_ack       <= '0;
      m_err       <= 1'b0;
      m_rdata     <= '0;
    end else begin
      m_ack <= '0;
      m_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx   <= w_gnt_idx;
            r_addr  <= m_addr[int'(w_gnt_idx)*AW +: AW];
            r_rw    <= m_rw[w_gnt_idx];
            r_wdata <= m_wdata[int'(w_gnt_idx)*DW +: DW];
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_hit       <= w_hit;
          r_id        <= w_id;
          addr        <= r_addr;
          RW          <= r_rw;
          DataToSlave <= r_wdata;
          r_state     <= XFER;
        end
        // Slave read data is combinational, so it is captured on the edge closing XFER.
        XFER: begin
          if (!r_rw) m_rdata <= r_hit ? DataFromSlave : '0;
          m_ack[r_idx] <= 1'b1;
          m_err        <= !r_hit;
          r_state      <= RESP;
        end
        RESP: begin
          r_ptr   <= w_ptr_nxt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_decode.sv
// Scoreboard bench for arb_rr_decode with a 16-slave counter model on the shared bus.
module tb_arb_rr_decode;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req;
  logic [127:0] m_addr;
  logic [3:0]   m_rw;
  logic [127:0] m_wdata;
  logic [3:0]   m_ack;
  logic         m_err;
  logic [31:0]  m_rdata;
  logic [15:0]  sel;
  logic [31:0]  addr;
  logic         RW;
  logic [31:0]  DataToSlave;
  logic [31:0]  DataFromSlave;

  arb_rr_decode dut (
    .clk           (clk),
    .rst           (rst),
    .m_req         (m_req),
    .m_addr        (m_addr),
    .m_rw          (m_rw),
    .m_wdata       (m_wdata),
    .m_ack         (m_ack),
    .m_err         (m_err),
    .m_rdata       (m_rdata),
    .sel           (sel),
    .addr          (addr),
    .RW            (RW),
    .DataToSlave   (DataToSlave),
    .DataFromSlave (DataFromSlave)
  );

  initial forever #5 clk = ~clk;

  // Slave model: read data = {4'h0, slave id, 24-bit read count}; counts writes and reads.
  int wr_cnt [16];
  int rd_cnt [16];

  always_comb begin
    DataFromSlave = '0;
    for (int s = 0; s < 16; s++)
      if (sel[s]) DataFromSlave = {4'h0, 4'(s), 24'(rd_cnt[s])};
  end

  always @(posedge clk) begin
    for (int s = 0; s < 16; s++)
      if (sel[s]) begin
        if (RW) wr_cnt[s] <= wr_cnt[s] + 1;
        else    rd_cnt[s] <= rd_cnt[s] + 1;
      end
  end

  typedef struct {
    int          mst;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel_id;
    bit          err;
    logic [31:0] rdata;
    int          t0;
    int          lat;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   sel_cnt  = 0;
  int   last_ack = 0;
  int   rearm0   = 0;
  int   w3, w7;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic issue(input int m, input logic [31:0] a, input bit rw, input logic [31:0] wd,
                       input int sid, input bit err, input logic [31:0] rd,
                       input int lat, input int gap);
    exp_t e;
    m_addr[m*32 +: 32]  = a;
    m_rw[m]             = rw;
    m_wdata[m*32 +: 32] = wd;
    m_req[m]            = 1'b1;
    e.mst = m;  e.rw = rw;   e.addr = a;  e.wdata = wd; e.sel_id = sid;
    e.err = err; e.rdata = rd; e.t0 = cyc; e.lat = lat;  e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic handle_ack();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("ack_unexpected", 64'(m_ack), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("ack_mst", 64'(m_ack), 64'd1 << e.mst);
    chk("ack_err", 64'(m_err), 64'(e.err));
    if (!e.rw) chk("rdata", 64'(m_rdata), 64'(e.rdata));
    chk("sel_cycles", 64'(sel_cnt), e.err ? 64'd0 : 64'd1);
    sel_cnt = 0;
    if (e.lat > 0) chk("latency", 64'(cyc - e.t0), 64'(e.lat));
    if (e.gap > 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
    last_ack = cyc;
    if (rearm0 > 0 && e.mst == 0) rearm0--;
    else m_req[e.mst] = 1'b0;
  endtask

  task automatic tick();
    exp_t        e;
    logic [63:0] want_sel;
    @(posedge clk);
    #1;
    cyc++;
    if (sel != '0) begin
      sel_cnt++;
      if (exp_q.size() == 0) chk("sel_unexpected", 64'(sel), 64'd0);
      else begin
        e = exp_q[0];
        want_sel = (e.sel_id < 0) ? 64'd0 : (64'd1 << e.sel_id);
        chk("sel_id", 64'(sel), want_sel);
        chk("bus_addr", 64'(addr), 64'(e.addr));
        chk("bus_rw", 64'(RW), 64'(e.rw));
        if (e.rw) chk("bus_wdata", 64'(DataToSlave), 64'(e.wdata));
      end
    end
    if (m_ack != '0) handle_ack();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      m_req = '0;
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_addr = '0; m_rw = '0; m_wdata = '0;
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_sel",   64'(sel),         64'd0);
    chk("rst_ack",   64'(m_ack),       64'd0);
    chk("rst_err",   64'(m_err),       64'd0);
    chk("rst_rdata", 64'(m_rdata),     64'd0);
    chk("rst_addr",  64'(addr),        64'd0);
    chk("rst_rw",    64'(RW),          64'd0);
    chk("rst_wdata", 64'(DataToSlave), 64'd0);
    rst = 1'b1;
    tick();

    // Complete one M2 transfer so the pointer moves off zero.
    issue(2, 32'hFFEF_6200, 1'b1, 32'hA5A5_0002, 6, 1'b0, 32'h0, 3, 0);
    wait_done(20);

    // Reset in the middle of an M3 XFER: transfer aborted, no ack, pointer back to 0.
    w7 = wr_cnt[7];
    issue(3, 32'hFFEF_7200, 1'b1, 32'h7777_0003, 7, 1'b0, 32'h0, 0, 0);
    tick();
    tick();
    chk("xfer_sel_seen", 64'(sel_cnt), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_sel",  64'(sel),   64'd0);
    chk("abort_ack",  64'(m_ack), 64'd0);
    chk("abort_addr", 64'(addr),  64'd0);
    exp_q.delete();
    sel_cnt = 0;
    tick();
    chk("abort_no_ack", 64'(m_ack), 64'd0);
    rst = 1'b1;

    // M3 still holds its request; M0 write must win first after reset.
    w3 = wr_cnt[3];
    issue(0, 32'hFFEF_3210, 1'b1, 32'h3000_0000, 3, 1'b0, 32'h0, 3, 0);
    issue(3, 32'hFFEF_7200, 1'b1, 32'h7777_0003, 7, 1'b0, 32'h0, 0, 4);
    wait_done(30);
    chk("slv3_wr", 64'(wr_cnt[3]), 64'(w3 + 1));
    chk("slv7_wr", 64'(wr_cnt[7]), 64'(w7 + 1));

    // All four masters at once; M0 keeps requesting after its first ack.
    rearm0 = 1;
    issue(0, 32'hFFEF_1200, 1'b1, 32'h1000_0000, 1, 1'b0, 32'h0, 3, 0);
    issue(1, 32'hFFEF_2200, 1'b1, 32'h2000_0001, 2, 1'b0, 32'h0, 0, 4);
    issue(2, 32'hFFEF_3200, 1'b1, 32'h3000_0002, 3, 1'b0, 32'h0, 0, 4);
    issue(3, 32'hFFEF_4200, 1'b1, 32'h4000_0003, 4, 1'b0, 32'h0, 0, 4);
    issue(0, 32'hFFEF_1200, 1'b1, 32'h1000_0000, 1, 1'b0, 32'h0, 0, 4);
    wait_done(60);

    // M1 reads slave 5 twice.
    issue(1, 32'hFFEF_5200, 1'b0, 32'h0, 5, 1'b0, 32'h0500_0000, 3, 0);
    wait_done(20);
    issue(1, 32'hFFEF_5200, 1'b0, 32'h0, 5, 1'b0, 32'h0500_0001, 3, 0);
    wait_done(20);

    // Read miss from M2: error, zero data, no select.
    issue(2, 32'h1234_0200, 1'b0, 32'h0, -1, 1'b1, 32'h0, 3, 0);
    wait_done(20);

    // Pointer now 3: M0 wins over M2 by wrapping; M2 write misses.
    issue(0, 32'hFFEF_5204, 1'b0, 32'h0, 5, 1'b0, 32'h0500_0002, 3, 0);
    issue(2, 32'hFFEE_7200, 1'b1, 32'hDEAD_BEEF, -1, 1'b1, 32'h0, 0, 4);
    wait_done(30);
    chk("rdata_hold", 64'(m_rdata), 64'h0500_0002);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
